// File: rtl/syscall_handler.sv
// syscall_handler: answers the processor's syscall interface.
//   EXIT  - latch exit code, flush pending output, then halt (busy forever).
//   WRITE - push {byte, stream} into a small transmit FIFO.
//   READ  - flush pending output, request one byte on the receive port,
//           return it as a one-cycle result pulse.
//   op 3  - reserved; sets a sticky error flag.
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_syscall_*                  request (sampled only while o_busy = 0)
//   o_busy                       stall to the processor
//   o_result_valid/data          READ result pulse
//   o_tx_valid/data/stream       transmit stream, popped on i_tx_ready
//   o_rx_req/stream, i_rx_*      receive request/response
//   o_exit_valid/code, o_error   sticky status
module syscall_handler #(
    parameter int unsigned OUT_DEPTH    = 4,
    parameter int unsigned STREAM_WIDTH = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_syscall_valid,
    input  logic [1:0]              i_syscall_op,
    input  logic [31:0]             i_syscall_arg0,
    input  logic [31:0]             i_syscall_arg1,
    output logic                    o_busy,
    output logic                    o_result_valid,
    output logic [31:0]             o_result_data,
    output logic                    o_tx_valid,
    output logic [7:0]              o_tx_data,
    output logic [STREAM_WIDTH-1:0] o_tx_stream,
    input  logic                    i_tx_ready,
    output logic                    o_rx_req,
    output logic [STREAM_WIDTH-1:0] o_rx_stream,
    input  logic                    i_rx_valid,
    input  logic [7:0]              i_rx_data,
    output logic                    o_exit_valid,
    output logic [31:0]             o_exit_code,
    output logic                    o_error
);

    localparam int unsigned AW = $clog2(OUT_DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] OpExit  = 2'd0;
    localparam logic [1:0] OpWrite = 2'd1;
    localparam logic [1:0] OpRead  = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StReadWait,
        StResp,
        StHalted
    } state_e;

    state_e                  state_q, state_d;
    logic                    drain_exit_q, drain_exit_d;  // DRAIN ends in HALTED, not READ_WAIT
    logic [STREAM_WIDTH-1:0] rd_stream_q, rd_stream_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             exit_code_q, exit_code_d;
    logic                    error_q, error_d;

    // Transmit FIFO storage and pointers
    logic [7:0]              mem_data_q   [OUT_DEPTH];
    logic [STREAM_WIDTH-1:0] mem_stream_q [OUT_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q;

    logic fifo_empty, fifo_full, busy, accept, push, pop;

    // Upper bits of the WRITE stream argument carry no meaning.
    logic unused_arg1;
    assign unused_arg1 = ^i_syscall_arg1[31:STREAM_WIDTH];

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(OUT_DEPTH));

    // Registers only: no combinational path from the request inputs.
    assign busy   = (state_q != StIdle) || fifo_full;
    assign accept = i_syscall_valid && !busy;
    assign push   = accept && (i_syscall_op == OpWrite);
    assign pop    = !fifo_empty && i_tx_ready;

    // FIFO storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q]   <= i_syscall_arg0[7:0];
            mem_stream_q[wr_ptr_q] <= i_syscall_arg1[STREAM_WIDTH-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= StIdle;
            drain_exit_q <= 1'b0;
            rd_stream_q  <= '0;
            rdata_q      <= '0;
            exit_code_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_exit_q <= drain_exit_d;
            rd_stream_q  <= rd_stream_d;
            rdata_q      <= rdata_d;
            exit_code_q  <= exit_code_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_exit_d = drain_exit_q;
        rd_stream_d  = rd_stream_q;
        rdata_d      = rdata_q;
        exit_code_d  = exit_code_q;
        error_d      = error_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    unique case (i_syscall_op)
                        OpExit: begin
                            exit_code_d  = i_syscall_arg0;
                            drain_exit_d = 1'b1;
                            state_d      = fifo_empty ? StHalted : StDrain;
                        end
                        OpWrite: ;  // handled by the FIFO push
                        OpRead: begin
                            rd_stream_d  = i_syscall_arg0[STREAM_WIDTH-1:0];
                            drain_exit_d = 1'b0;
                            state_d      = fifo_empty ? StReadWait : StDrain;
                        end
                        default: error_d = 1'b1;
                    endcase
                end
            end
            // Pending output leaves before input is requested or the halt shows.
            StDrain: begin
                if (fifo_empty) begin
                    state_d = drain_exit_q ? StHalted : StReadWait;
                end
            end
            StReadWait: begin
                if (i_rx_valid) begin
                    rdata_d = {24'h0, i_rx_data};
                    state_d = StResp;
                end
            end
            StResp:   state_d = StIdle;
            StHalted: state_d = StHalted;
            default:  state_d = StIdle;
        endcase
    end

    assign o_busy         = busy;
    assign o_result_valid = (state_q == StResp);
    assign o_result_data  = rdata_q;
    assign o_tx_valid     = !fifo_empty;
    // Gate head data so the port reads zero while the FIFO is empty.
    assign o_tx_data      = fifo_empty ? 8'h00 : mem_data_q[rd_ptr_q];
    assign o_tx_stream    = fifo_empty ? '0 : mem_stream_q[rd_ptr_q];
    assign o_rx_req       = (state_q == StReadWait);
    assign o_rx_stream    = o_rx_req ? rd_stream_q : '0;
    assign o_exit_valid   = (state_q == StHalted);
    assign o_exit_code    = exit_code_q;
    assign o_error        = error_q;

endmodule

// File: tb/tb_syscall_handler.sv
module tb_syscall_handler;

    localparam int SW = 2;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_syscall_valid;
    logic [1:0]    i_syscall_op;
    logic [31:0]   i_syscall_arg0, i_syscall_arg1;
    logic          o_busy, o_result_valid;
    logic [31:0]   o_result_data;
    logic          o_tx_valid;
    logic [7:0]    o_tx_data;
    logic [SW-1:0] o_tx_stream;
    logic          i_tx_ready;
    logic          o_rx_req;
    logic [SW-1:0] o_rx_stream;
    logic          i_rx_valid;
    logic [7:0]    i_rx_data;
    logic          o_exit_valid;
    logic [31:0]   o_exit_code;
    logic          o_error;

    syscall_handler #(.OUT_DEPTH(4), .STREAM_WIDTH(SW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_syscall_valid(i_syscall_valid), .i_syscall_op(i_syscall_op),
        .i_syscall_arg0(i_syscall_arg0), .i_syscall_arg1(i_syscall_arg1),
        .o_busy(o_busy), .o_result_valid(o_result_valid), .o_result_data(o_result_data),
        .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .o_tx_stream(o_tx_stream),
        .i_tx_ready(i_tx_ready), .o_rx_req(o_rx_req), .o_rx_stream(o_rx_stream),
        .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
        .o_exit_valid(o_exit_valid), .o_exit_code(o_exit_code), .o_error(o_error)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]    d;
        logic [SW-1:0] s;
    } tx_t;

    typedef struct {
        logic [31:0]   a0;
        logic [31:0]   a1;
        logic [7:0]    ed;
        logic [SW-1:0] es;
    } wvec_t;

    typedef struct {
        logic [SW-1:0] s;
        logic [7:0]    rd;
        logic [31:0]   er;
    } rvec_t;

    tx_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    bit  rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sampled mid-cycle: a pop happens at the next rising edge.
    always @(negedge i_clk) begin
        tx_t e;
        if (!i_rst && o_tx_valid && i_tx_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_unexpected: got 0x%0h, expected no byte", o_tx_data);
            end else begin
                e = sb.pop_front();
                chk("tx_data", 32'(o_tx_data), 32'(e.d));
                chk("tx_stream", 32'(o_tx_stream), 32'(e.s));
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (rand_rdy) i_tx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] a0, input logic [31:0] a1);
        int budget = 300;
        i_syscall_valid = 1'b1;
        i_syscall_op    = op;
        i_syscall_arg0  = a0;
        i_syscall_arg1  = a1;
        while (o_busy && budget > 0) begin
            tick();
            budget--;
        end
        if (o_busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_accept_timeout: busy=1, expected 0");
        end
        tick();
        i_syscall_valid = 1'b0;
    endtask

    task automatic write_b(input logic [7:0] d, input logic [SW-1:0] s);
        sb.push_back(tx_t'{d, s});
        do_req(2'd1, {24'hA5A5A5, d}, {{(32 - SW){1'b1}}, s});
    endtask

    task automatic wait_drain(input string name);
        int budget = 400;
        while ((sb.size() != 0 || o_tx_valid) && budget > 0) begin
            tick();
            budget--;
        end
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic finish_read(input logic [SW-1:0] s, input logic [7:0] rd,
                               input logic [31:0] er);
        int budget = 300;
        while (!o_rx_req && budget > 0) begin
            tick();
            budget--;
        end
        chk("rx_req", 32'(o_rx_req), 32'd1);
        chk("rx_stream", 32'(o_rx_stream), 32'(s));
        chk("flushed_before_req", 32'(sb.size()), 32'd0);
        i_rx_valid = 1'b1;
        i_rx_data  = rd;
        tick();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'hEE;
        chk("result_valid", 32'(o_result_valid), 32'd1);
        chk("result_data", o_result_data, er);
        tick();
        chk("result_pulse_end", 32'(o_result_valid), 32'd0);
        chk("busy_after_read", 32'(o_busy), 32'd0);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_flags"}, {26'h0, o_busy, o_result_valid, o_tx_valid, o_rx_req,
            o_exit_valid, o_error}, 32'd0);
        chk({name, "_result"}, o_result_data, 32'd0);
        chk({name, "_exitcode"}, o_exit_code, 32'd0);
        chk({name, "_ports"}, 32'({o_tx_data, o_tx_stream, o_rx_stream}), 32'd0);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear at once.
    task automatic reset_mid(input string name);
        #2;
        i_rst = 1'b1;
        #1;
        chk_zero({name, "_during"});
        sb.delete();
        @(posedge i_clk);
        #1;
        i_rst      = 1'b0;
        i_rx_valid = 1'b0;
        tick();
        chk_zero({name, "_after"});
    endtask

    wvec_t wv[4];
    rvec_t rv[3];

    initial begin
        wv[0] = '{32'h0000_0041, 32'h0000_0001, 8'h41, 2'd1};
        wv[1] = '{32'hDEAD_BEEF, 32'hFFFF_FFFE, 8'hEF, 2'd2};
        wv[2] = '{32'h1234_5600, 32'h0000_0007, 8'h00, 2'd3};
        wv[3] = '{32'hFFFF_FF80, 32'h8000_0000, 8'h80, 2'd0};
        rv[0] = '{2'd0, 8'h00, 32'h0000_0000};
        rv[1] = '{2'd3, 8'hFF, 32'h0000_00FF};
        rv[2] = '{2'd1, 8'h5A, 32'h0000_005A};

        i_rst = 1'b1;
        i_syscall_valid = 1'b0;
        i_syscall_op = 2'd0;
        i_syscall_arg0 = '0;
        i_syscall_arg1 = '0;
        i_tx_ready = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data = 8'h00;
        repeat (2) @(posedge i_clk);
        #1;
        chk_zero("reset");
        i_rst = 1'b0;
        tick();
        chk_zero("reset_release");

        // WRITE vectors: upper argument bits ignored; byte visible the cycle after accept
        for (int i = 0; i < 4; i++) begin
            sb.push_back(tx_t'{wv[i].ed, wv[i].es});
            do_req(2'd1, wv[i].a0, wv[i].a1);
            chk("tx_valid_t1", 32'(o_tx_valid), 32'd1);
        end
        wait_drain("write_table_drain");

        // READ vectors with empty FIFO: request from t+1
        for (int i = 0; i < 3; i++) begin
            do_req(2'd2, {{(32 - SW){1'b1}}, rv[i].s}, 32'h0);
            chk("rx_req_t1", 32'(o_rx_req), 32'd1);
            finish_read(rv[i].s, rv[i].rd, rv[i].er);
        end

        // rx response outside READ_WAIT is ignored
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h99;
        repeat (2) tick();
        i_rx_valid = 1'b0;
        chk("rx_ignored_idle", 32'({o_result_valid, o_busy, o_rx_req}), 32'd0);

        // Fill to full with ready low; fifth request held while busy
        i_tx_ready = 1'b0;
        for (int k = 0; k < 4; k++) write_b(8'(8'h41 + k), 2'd1);
        chk("busy_when_full", 32'(o_busy), 32'd1);
        sb.push_back(tx_t'{8'h45, 2'd1});
        i_syscall_valid = 1'b1;
        i_syscall_op    = 2'd1;
        i_syscall_arg0  = 32'h0000_0045;
        i_syscall_arg1  = 32'h0000_0001;
        repeat (3) begin
            tick();
            chk("busy_held_full", 32'(o_busy), 32'd1);
        end
        i_tx_ready = 1'b1;
        tick();
        chk("busy_drop_first_pop", 32'(o_busy), 32'd0);
        tick();
        i_syscall_valid = 1'b0;
        wait_drain("full_drain");

        // READ behind a queued prompt: request only after the prompt leaves
        i_tx_ready = 1'b0;
        write_b(8'h3F, 2'd1);
        do_req(2'd2, 32'h0000_0002, 32'h0);
        repeat (3) begin
            tick();
            chk("rx_req_blocked", 32'(o_rx_req), 32'd0);
            chk("busy_drain", 32'(o_busy), 32'd1);
        end
        i_tx_ready = 1'b1;
        finish_read(2'd2, 8'h7A, 32'h0000_007A);

        // Simultaneous push and pop at count 2
        i_tx_ready = 1'b0;
        write_b(8'h21, 2'd3);
        write_b(8'h22, 2'd3);
        chk("count_two", 32'(dut.count_q), 32'd2);
        sb.push_back(tx_t'{8'h23, 2'd3});
        i_syscall_valid = 1'b1;
        i_syscall_op    = 2'd1;
        i_syscall_arg0  = 32'h0000_0023;
        i_syscall_arg1  = 32'h0000_0003;
        i_tx_ready      = 1'b1;
        tick();
        i_syscall_valid = 1'b0;
        chk("count_push_pop", 32'(dut.count_q), 32'd2);
        wait_drain("pushpop_drain");

        // Pointer wrap with random ready
        rand_rdy = 1'b1;
        for (int i = 0; i < 20; i++) write_b(8'(i), 2'(i));
        wait_drain("wrap_drain");
        rand_rdy   = 1'b0;
        i_tx_ready = 1'b1;

        // Reserved op: sticky error, stays usable
        do_req(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("error_set", 32'(o_error), 32'd1);
        chk("error_idle", 32'(o_busy), 32'd0);
        write_b(8'h10, 2'd0);
        chk("write_after_error", 32'(o_tx_valid), 32'd1);
        wait_drain("error_drain");
        chk("error_sticky", 32'(o_error), 32'd1);

        // Reset mid-drain with bytes queued, then mid-READ_WAIT with response pending
        i_tx_ready = 1'b0;
        do_req(2'd1, 32'h0000_0055, 32'h1);
        do_req(2'd1, 32'h0000_0066, 32'h1);
        do_req(2'd2, 32'h0000_0001, 32'h0);
        chk("busy_in_drain", 32'(o_busy), 32'd1);
        reset_mid("rst_drain");
        i_tx_ready = 1'b1;
        repeat (2) tick();
        do_req(2'd2, 32'h0000_0003, 32'h0);
        chk("rx_req_before_rst", 32'(o_rx_req), 32'd1);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'hC3;
        reset_mid("rst_readwait");
        chk("no_result_after_rst", 32'(o_result_valid), 32'd0);

        // EXIT with two bytes queued
        i_tx_ready = 1'b0;
        write_b(8'hA1, 2'd2);
        write_b(8'hA2, 2'd2);
        do_req(2'd0, 32'h0000_0005, 32'h0);
        repeat (3) begin
            tick();
            chk("exit_wait_drain", 32'(o_exit_valid), 32'd0);
        end
        i_tx_ready = 1'b1;
        begin
            int budget = 50;
            while (!o_exit_valid && budget > 0) begin
                tick();
                budget--;
            end
        end
        chk("exit_valid", 32'(o_exit_valid), 32'd1);
        chk("exit_after_flush", 32'(sb.size()), 32'd0);
        chk("exit_code", o_exit_code, 32'h0000_0005);
        i_syscall_valid = 1'b1;
        i_syscall_op    = 2'd1;
        i_syscall_arg0  = 32'h0000_0077;
        repeat (4) tick();
        i_syscall_op = 2'd2;
        repeat (2) tick();
        i_syscall_valid = 1'b0;
        chk("halted_busy", 32'(o_busy), 32'd1);
        chk("halted_ignores", 32'({o_tx_valid, o_rx_req, o_result_valid}), 32'd0);
        chk("halted_sticky", 32'(o_exit_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
